// File: rtl/time_set_controller_pkg.sv
// Shared definitions for the digital clock time-keeping path.
//   state_e      : set-mode FSM states (RUN, SET_HOUR, SET_MIN)
//   *_MAX/*_MIN  : field limits for seconds, minutes and both hour formats
//   units_t etc. : BCD digit field types
package time_set_controller_pkg;

  typedef enum logic [1:0] {
    RUN,
    SET_HOUR,
    SET_MIN
  } state_e;

  localparam int unsigned SEC_MAX     = 59;
  localparam int unsigned MIN_MAX     = 59;
  localparam int unsigned HOUR_MAX_24 = 23;
  localparam int unsigned HOUR_MIN_12 = 1;
  localparam int unsigned HOUR_MAX_12 = 12;

  typedef logic [3:0] units_t;
  typedef logic [2:0] min_tens_t;
  typedef logic [1:0] hour_tens_t;

endpackage

// File: rtl/time_set_controller_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter (units + tens) counting
// MIN_VAL..MAX_VAL and wrapping back to MIN_VAL.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, loads RST_VAL
//   inc_i   : one-cycle increment request
//   units_o : units digit (registered)
//   tens_o  : tens digit (registered)
//   wrap_o  : high in the cycle an increment wraps MAX_VAL -> MIN_VAL
//             (combinational, so a carry chain settles in one edge)
import time_set_controller_pkg::*;

module bcd_mod_counter #(
  parameter int unsigned TENS_W  = 3,
  parameter int unsigned MAX_VAL = 59,
  parameter int unsigned MIN_VAL = 0,
  parameter int unsigned RST_VAL = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inc_i,
  output units_t            units_o,
  output logic [TENS_W-1:0] tens_o,
  output logic              wrap_o
);

  localparam units_t            MAX_U = units_t'(MAX_VAL % 10);
  localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX_VAL / 10);
  localparam units_t            MIN_U = units_t'(MIN_VAL % 10);
  localparam logic [TENS_W-1:0] MIN_T = TENS_W'(MIN_VAL / 10);
  localparam units_t            RST_U = units_t'(RST_VAL % 10);
  localparam logic [TENS_W-1:0] RST_T = TENS_W'(RST_VAL / 10);

  units_t            units_q, units_d;
  logic [TENS_W-1:0] tens_q,  tens_d;
  logic              at_max;

  assign at_max = (units_q == MAX_U) && (tens_q == MAX_T);
  assign wrap_o = inc_i && at_max;

  always_comb begin
    units_d = units_q;
    tens_d  = tens_q;
    if (inc_i) begin
      if (at_max) begin
        units_d = MIN_U;
        tens_d  = MIN_T;
      end else if (units_q == 4'd9) begin
        units_d = '0;
        tens_d  = tens_q + TENS_W'(1);
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      units_q <= RST_U;
      tens_q  <= RST_T;
    end else begin
      units_q <= units_d;
      tens_q  <= tens_d;
    end
  end

  assign units_o = units_q;
  assign tens_o  = tens_q;

endmodule

// File: rtl/time_set_controller.sv
// time_set_controller: seconds/minutes/hours timekeeping plus the
// RUN -> SET_HOUR -> SET_MIN set-mode sequencer and display blink gating.
//   clk, rst            : clock, synchronous active-high reset
//   sec_tick            : one-cycle once-per-second strobe
//   btn_mode, btn_inc   : one-cycle debounced button pulses
//   rightMin, leftMin   : minutes BCD units / tens
//   rightHour, leftHour : hours BCD units / tens
//   pm                  : PM flag (tied 0 in the 24h build)
//   set_active          : high in SET_HOUR / SET_MIN
//   show_min, show_hour : display enables, blinking for the field being set
// Build option: define TWELVE_HOUR_EN for a 12,1..11 hour display with pm.
import time_set_controller_pkg::*;

module time_set_controller #(
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] rightMin,
  output logic [2:0] leftMin,
  output logic [3:0] rightHour,
  output logic [1:0] leftHour,
  output logic       pm,
  output logic       set_active,
  output logic       show_min,
  output logic       show_hour
);

  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  state_e               state_q, state_d;
  logic [5:0]           sec_q, sec_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic                 set_active_q, set_active_d;
  logic                 show_min_q, show_min_d;
  logic                 show_hour_q, show_hour_d;

  logic run, inc_ok, sec_wrap, min_inc, min_wrap, hour_inc;
  logic unused_hour_wrap;

  assign run    = (state_q == RUN);
  // A mode press in the same cycle swallows the increment.
  assign inc_ok = btn_inc && !btn_mode;

  assign sec_wrap = run && sec_tick && (sec_q == 6'(SEC_MAX));
  assign min_inc  = sec_wrap || ((state_q == SET_MIN) && inc_ok);
  // Minute wrap only carries while running; set-mode wraps stay local.
  assign hour_inc = (run && min_wrap) || ((state_q == SET_HOUR) && inc_ok);

  bcd_mod_counter #(
    .TENS_W  (3),
    .MAX_VAL (MIN_MAX),
    .MIN_VAL (0),
    .RST_VAL (0)
  ) u_min (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (min_inc),
    .units_o (rightMin),
    .tens_o  (leftMin),
    .wrap_o  (min_wrap)
  );

  bcd_mod_counter #(
    .TENS_W  (2),
`ifdef TWELVE_HOUR_EN
    .MAX_VAL (HOUR_MAX_12),
    .MIN_VAL (HOUR_MIN_12),
    .RST_VAL (HOUR_MAX_12)
`else
    .MAX_VAL (HOUR_MAX_24),
    .MIN_VAL (0),
    .RST_VAL (0)
`endif
  ) u_hour (
    .clk_i   (clk),
    .rst_i   (rst),
    .inc_i   (hour_inc),
    .units_o (rightHour),
    .tens_o  (leftHour),
    .wrap_o  (unused_hour_wrap)
  );

  always_comb begin
    state_d = state_q;
    if (btn_mode) begin
      case (state_q)
        RUN:      state_d = SET_HOUR;
        SET_HOUR: state_d = SET_MIN;
        default:  state_d = RUN;
      endcase
    end

    sec_d = sec_q;
    if ((state_q == SET_MIN) && btn_mode) begin
      sec_d = '0;
    end else if (run && sec_tick) begin
      sec_d = sec_wrap ? 6'd0 : sec_q + 6'd1;
    end

    // Blink restarts visible on every state change.
    if (state_d != state_q) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      phase_d     = phase_q;
    end

    set_active_d = (state_d != RUN);
    show_hour_d  = (state_d == SET_HOUR) ? phase_d : 1'b1;
    show_min_d   = (state_d == SET_MIN)  ? phase_d : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      sec_q        <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      set_active_q <= 1'b0;
      show_min_q   <= 1'b1;
      show_hour_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      sec_q        <= sec_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      set_active_q <= set_active_d;
      show_min_q   <= show_min_d;
      show_hour_q  <= show_hour_d;
    end
  end

`ifdef TWELVE_HOUR_EN
  logic pm_q;
  // pm flips when the hour steps 11 -> 12, whether by carry or by button.
  always_ff @(posedge clk) begin
    if (rst) begin
      pm_q <= 1'b0;
    end else if (hour_inc && (leftHour == 2'd1) && (rightHour == 4'd1)) begin
      pm_q <= ~pm_q;
    end
  end
  assign pm = pm_q;
`else
  assign pm = 1'b0;
`endif

  assign set_active = set_active_q;
  assign show_min   = show_min_q;
  assign show_hour  = show_hour_q;

endmodule
